// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and load/store requests onto one memory port, aborting a grant after TIMEOUT cycles.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN alternates simultaneous grants; when undefined, data requests always win.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_address_enable,
  input  logic [31:0] fetch_address,
  output logic        fetch_data_valid,
  output logic [31:0] fetch_data,
  input  logic        data_address_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic [31:0] data_write_data,
  output logic        data_data_valid,
  output logic [31:0] data_data,
  output logic        mem_address_enable,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data,
  output logic        timeout_error
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             dropped;
  logic             pick_fetch;
  logic             req_live;
  logic             done;
  logic             expire;
  logic             deliver;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_data;
  assign pick_fetch = fetch_address_enable && (!data_address_enable || last_data);
`else
  assign pick_fetch = fetch_address_enable && !data_address_enable;
`endif

  // A response is only handed back if the granted requester kept asking for the whole grant.
  assign req_live = (state == FETCH) ? fetch_address_enable : data_address_enable;
  assign done     = (state != IDLE) && mem_data_valid;
  assign expire   = (state != IDLE) && !mem_data_valid && (wait_cnt == LAST_WAIT);
  assign deliver  = done && req_live && !dropped;

  assign mem_address_enable = (state != IDLE);
  assign timeout_error      = expire;
  assign fetch_data_valid   = deliver && (state == FETCH);
  assign data_data_valid    = deliver && (state == DATA);
  assign fetch_data         = fetch_data_valid ? mem_data : 32'd0;
  assign data_data          = data_data_valid ? mem_data : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      dropped        <= 1'b0;
      mem_address    <= '0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_data      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          dropped  <= 1'b0;
          if (pick_fetch) begin
            state          <= FETCH;
            mem_address    <= fetch_address;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_data      <= 1'b0;
`endif
          end else if (data_address_enable) begin
            state          <= DATA;
            mem_address    <= data_address;
            mem_write      <= data_write;
            mem_write_data <= data_write_data;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_data      <= 1'b1;
`endif
          end
        end
        default: begin
          if (done || expire) state <= IDLE;
          else wait_cnt <= wait_cnt + CNT_W'(1);
          if (!req_live) dropped <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench; the bench plays both requesters and the memory,
// predicting every grant and response from transaction-level arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_address_enable;
  logic [31:0] fetch_address;
  logic        fetch_data_valid;
  logic [31:0] fetch_data;
  logic        data_address_enable;
  logic [31:0] data_address;
  logic        data_write;
  logic [31:0] data_write_data;
  logic        data_data_valid;
  logic [31:0] data_data;
  logic        mem_address_enable;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic        mem_data_valid;
  logic [31:0] mem_data;
  logic        timeout_error;

  int n_checks = 0;
  int n_fail   = 0;
  // Model state: which requester was granted most recently (1 = data), as set by reset.
  logic model_last_data = 1'b1;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .fetch_address_enable(fetch_address_enable), .fetch_address(fetch_address),
    .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
    .data_address_enable(data_address_enable), .data_address(data_address),
    .data_write(data_write), .data_write_data(data_write_data),
    .data_data_valid(data_data_valid), .data_data(data_data),
    .mem_address_enable(mem_address_enable), .mem_address(mem_address),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [132:0] all_out();
    return {mem_address_enable, mem_address, mem_write, mem_write_data,
            fetch_data_valid, fetch_data, data_data_valid, data_data, timeout_error};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    fetch_address_enable = 1'b0;
    data_address_enable  = 1'b0;
    data_write           = 1'b0;
    mem_data_valid       = 1'b0;
    mem_data             = 32'd0;
  endtask

  task automatic quiesce();
    next_cycle();
    idle_inputs();
  endtask

  function automatic logic model_pick_data(input logic f_en, input logic d_en);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return d_en && (!f_en || !model_last_data);
`else
    return d_en;
`endif
  endfunction

  // One transaction: an idle cycle presenting the requests, then grant cycles until response or timeout.
  // delay = grant cycle (1-based) in which memory answers; delay > TO means memory never answers.
  task automatic run_txn(input string tag, input logic f_en, input logic d_en,
                         input logic [31:0] f_addr, input logic [31:0] d_addr,
                         input logic d_wr, input logic [31:0] d_wd, input logic [31:0] rdata,
                         input int delay, input logic drop, output logic got_data);
    logic        exp_data;
    logic        fin, tmo, exp_fv, exp_dv;
    logic [31:0] exp_addr;
    bit          finished;
    finished = 0;
    got_data = 1'b0;
    next_cycle();
    fetch_address_enable = f_en;
    fetch_address        = f_addr;
    data_address_enable  = d_en;
    data_address         = d_addr;
    data_write           = d_wr;
    data_write_data      = d_wd;
    mem_data_valid       = 1'($urandom_range(0, 1));
    mem_data             = $urandom;
    settle();
    n_checks++;
    if ({mem_address_enable, fetch_data_valid, data_data_valid, timeout_error} !== 4'b0000)
      $display("FAIL %s idle: en/fv/dv/to=%b expected 0000", tag,
               {mem_address_enable, fetch_data_valid, data_data_valid, timeout_error});
    if ({mem_address_enable, fetch_data_valid, data_data_valid, timeout_error} !== 4'b0000) n_fail++;
    exp_data        = model_pick_data(f_en, d_en);
    model_last_data = exp_data;
    exp_addr        = exp_data ? d_addr : f_addr;
    for (int k = 1; k <= int'(TO) && !finished; k++) begin
      next_cycle();
      if (drop && k == 1) begin
        fetch_address_enable = 1'b0;
        data_address_enable  = 1'b0;
      end
      fin            = (k == delay);
      tmo            = !fin && (k == int'(TO));
      mem_data_valid = fin;
      mem_data       = fin ? rdata : $urandom;
      settle();
      exp_fv = fin && !exp_data && !drop;
      exp_dv = fin && exp_data && !drop;
      n_checks++;
      if ({mem_address_enable, mem_address, mem_write} !== {1'b1, exp_addr, exp_data & d_wr}) begin
        n_fail++;
        $display("FAIL %s grant k=%0d: en=%b addr=%h wr=%b expected en=1 addr=%h wr=%b", tag, k,
                 mem_address_enable, mem_address, mem_write, exp_addr, exp_data & d_wr);
      end
      if (exp_data && d_wr) begin
        n_checks++;
        if (mem_write_data !== d_wd) begin
          n_fail++;
          $display("FAIL %s wdata k=%0d: %h expected %h", tag, k, mem_write_data, d_wd);
        end
      end
      n_checks++;
      if ({fetch_data_valid, fetch_data} !== {exp_fv, exp_fv ? rdata : 32'd0}) begin
        n_fail++;
        $display("FAIL %s fetch_resp k=%0d: v=%b d=%h expected v=%b d=%h", tag, k,
                 fetch_data_valid, fetch_data, exp_fv, exp_fv ? rdata : 32'd0);
      end
      n_checks++;
      if ({data_data_valid, data_data} !== {exp_dv, exp_dv ? rdata : 32'd0}) begin
        n_fail++;
        $display("FAIL %s data_resp k=%0d: v=%b d=%h expected v=%b d=%h", tag, k,
                 data_data_valid, data_data, exp_dv, exp_dv ? rdata : 32'd0);
      end
      n_checks++;
      if (timeout_error !== tmo) begin
        n_fail++;
        $display("FAIL %s timeout k=%0d: %b expected %b", tag, k, timeout_error, tmo);
      end
      if (fin) got_data = data_data_valid;
      if (fin || tmo) finished = 1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    fetch_address   = $urandom;
    data_address    = $urandom;
    data_write_data = $urandom;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    model_last_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_data_valid = 1'b1;
      mem_data       = $urandom;
      settle();
      n_checks++;
      if (all_out() !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: %h expected 0", i, all_out());
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fetch();
    logic g;
    run_txn("fetch", 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 3, 1'b0, g);
  endtask

  task automatic test_store();
    logic g;
    run_txn("store", 1'b0, 1'b1, 32'h0, 32'h200, 1'b1, 32'h12345678, 32'h0, 2, 1'b0, g);
  endtask

  task automatic test_timeout();
    logic g;
    run_txn("timeout", 1'b1, 1'b0, $urandom, 32'h0, 1'b0, 32'h0, $urandom, int'(TO) + 1, 1'b0, g);
    run_txn("late_ok", 1'b0, 1'b1, 32'h0, $urandom, 1'b0, $urandom, $urandom, int'(TO), 1'b0, g);
  endtask

  task automatic test_drop();
    logic g;
    run_txn("drop", 1'b1, 1'b0, $urandom, 32'h0, 1'b0, 32'h0, $urandom, 2, 1'b1, g);
    run_txn("after_drop", 1'b0, 1'b1, 32'h0, $urandom, 1'b0, 32'h0, $urandom, 1, 1'b0, g);
  endtask

  task automatic test_back_to_back();
    logic g, exp;
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    model_last_data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_txn("b2b", 1'b1, 1'b1, $urandom, $urandom, 1'b0, 32'h0, $urandom, 1, 1'b0, g);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp = (i % 2 == 1);
`else
      exp = 1'b1;
`endif
      n_checks++;
      if (g !== exp) begin
        n_fail++;
        $display("FAIL b2b_order grant %0d: data_won=%b expected %b", i, g, exp);
      end
    end
  endtask

  task automatic test_random();
    logic g;
    int   sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(1, 3));
      run_txn("random", sel[0], sel[1], $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
              $urandom, int'($urandom_range(1, TO + 1)), ($urandom_range(0, 7) == 0), g);
    end
  endtask

  task automatic test_reset_mid();
    quiesce();
    next_cycle();
    fetch_address_enable = 1'b1;
    fetch_address        = $urandom;
    next_cycle();
    settle();
    n_checks++;
    if (mem_address_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid grant: en=%b expected 1", mem_address_enable);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    fetch_address_enable = 1'b0;
    model_last_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_data_valid = 1'b1;
      mem_data       = $urandom;
      settle();
      n_checks++;
      if (all_out() !== '0) begin
        n_fail++;
        $display("FAIL reset_mid outputs cycle %0d: %h expected 0", i, all_out());
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    reset           = 1'b1;
    fetch_address   = 32'd0;
    data_address    = 32'd0;
    data_write_data = 32'd0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_timeout();
    test_drop();
    test_back_to_back();
    quiesce();
    test_random();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
